// File: rtl/game_tick_sched.sv
// game_tick_sched: phase-aligned enable strobes for invader, player, shot and charge channels
module game_tick_sched #(
  parameter int CNT_W         = 27,
  parameter int INV_BASE      = 738281,
  parameter int LVL_STEP      = 65536,
  parameter int INV_MIN       = 131072,
  parameter int PLAYER_PERIOD = 184570,
  parameter int SHOT_PERIOD   = 92285,
  parameter int CHARGE_PERIOD = 23625000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             lvl_start,
  input  logic [2:0]       level,
  output logic             inv_tick,
  output logic             player_tick,
  output logic             shot_tick,
  output logic             charge_tick,
  output logic [CNT_W-1:0] inv_period,
  output logic [1:0]       state
);
  typedef enum logic [1:0] {IDLE, LOAD, RUN, PAUSE} state_t;
  localparam int PW = CNT_W + 3;
  state_t cur, nxt;
  logic [PW-1:0] prod, base;
  logic [CNT_W-1:0] new_period;
  logic [CNT_W-1:0] cnt [4];
  logic [CNT_W-1:0] per [4];
  logic [3:0] tick;
  assign prod = PW'(level) * PW'(LVL_STEP);
  assign base = PW'(INV_BASE);
  // Underflow and sub-floor results both collapse to the floor period
  assign new_period = (prod > base || base - prod < PW'(INV_MIN)) ? CNT_W'(INV_MIN) : CNT_W'(base - prod);
  assign per[0] = CNT_W'(CHARGE_PERIOD);
  assign per[1] = CNT_W'(SHOT_PERIOD);
  assign per[2] = CNT_W'(PLAYER_PERIOD);
  assign per[3] = inv_period;
  always_comb begin
    nxt = lvl_start ? LOAD : (cur == IDLE) ? IDLE : run ? RUN : PAUSE;
  end
  // lvl_start clears immediately so no stale tick shows during the LOAD cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur <= IDLE;
      inv_period <= CNT_W'(INV_BASE);
      tick <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      cur <= nxt;
      if (cur == LOAD) inv_period <= new_period;
      for (int i = 0; i < 4; i++) begin
        if (lvl_start || cur == LOAD) begin
          cnt[i] <= '0;
          tick[i] <= 1'b0;
        end else if (cur == RUN) begin
          cnt[i] <= (cnt[i] == per[i] - CNT_W'(1)) ? '0 : cnt[i] + CNT_W'(1);
          tick[i] <= cnt[i] == per[i] - CNT_W'(1);
        end else begin
          tick[i] <= 1'b0;
        end
      end
    end
  end
  assign {inv_tick, player_tick, shot_tick, charge_tick} = tick;
  assign state = cur;
endmodule

// File: tb/tb_game_tick_sched.sv
// tb_game_tick_sched: directed and randomized checks of game_tick_sched against a run-count model
module tb_game_tick_sched;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, lvl_start = 1'b0;
  logic [2:0] level = 3'd0;
  logic inv_tick, player_tick, shot_tick, charge_tick;
  logic [7:0] inv_period;
  logic [1:0] state;
  logic [3:0] dut_tick;
  int n_checks = 0, n_fail = 0;
  int m_state, m_inv;
  int runs [4];
  logic [3:0] m_tick;

  game_tick_sched #(.CNT_W(8), .INV_BASE(20), .LVL_STEP(4), .INV_MIN(6),
    .PLAYER_PERIOD(5), .SHOT_PERIOD(3), .CHARGE_PERIOD(50)) dut (
    .clk(clk), .rst(rst), .run(run), .lvl_start(lvl_start), .level(level),
    .inv_tick(inv_tick), .player_tick(player_tick), .shot_tick(shot_tick),
    .charge_tick(charge_tick), .inv_period(inv_period), .state(state));

  assign dut_tick = {inv_tick, player_tick, shot_tick, charge_tick};
  always #5 clk = ~clk;

  // Tick bit order {inv, player, shot, charge}
  function automatic int per(input int i);
    return i == 3 ? m_inv : i == 2 ? 5 : i == 1 ? 3 : 50;
  endfunction

  task automatic m_reset();
    m_state = 0; m_inv = 20; m_tick = '0;
    for (int i = 0; i < 4; i++) runs[i] = 0;
  endtask

  // A channel ticks when its count of RUN cycles since the last realign is a multiple of its period
  task automatic step(input logic r, input logic ls, input int lv);
    run = r; lvl_start = ls; level = 3'(lv);
    for (int i = 0; i < 4; i++)
      if (ls || m_state == 1) begin runs[i] = 0; m_tick[i] = 1'b0; end
      else if (m_state == 2) begin runs[i]++; m_tick[i] = (runs[i] % per(i) == 0); end
      else m_tick[i] = 1'b0;
    if (m_state == 1) m_inv = (20 - 4 * lv < 6) ? 6 : 20 - 4 * lv;
    m_state = ls ? 1 : (m_state == 0) ? 0 : r ? 2 : 3;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
    for (int c = 0; c < 100; c++) begin
      step(1'b1, 1'b0, 0);
      n_checks++;
      if ({state, dut_tick, inv_period} !== {2'd0, 4'd0, 8'd20}) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d state=%0d ticks=%b inv_period=%0d, want 0 0000 20", c, state, dut_tick, inv_period);
      end
    end
  endtask

  task automatic test_align();
    step(1'b1, 1'b1, 0);
    n_checks++;
    if (state !== 2'd1) begin n_fail++; $display("FAIL align_load state=%0d want 1", state); end
    // Cycle 0 is the first RUN cycle
    for (int c = 0; c <= 40; c++) begin
      if (c > 0) step(1'b1, 1'b0, 0); else step(1'b1, 1'b0, 0);
      n_checks++;
      if ({state, dut_tick} !== {2'd2, c % 20 == 0 && c > 0, c % 5 == 0 && c > 0, c % 3 == 0 && c > 0, 1'b0}) begin
        n_fail++;
        $display("FAIL align c=%0d state=%0d ticks=%b want state 2 ticks %b", c, state, dut_tick,
          {c % 20 == 0 && c > 0, c % 5 == 0 && c > 0, c % 3 == 0 && c > 0, 1'b0});
      end
    end
  endtask

  task automatic test_levels();
    int lvs [3] = '{2, 5, 7};
    int exp_p [3] = '{12, 6, 6};
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, lvs[k]);
      n_checks++;
      if ({state, dut_tick} !== {2'd1, 4'd0}) begin
        n_fail++; $display("FAIL level_load lv=%0d state=%0d ticks=%b want 1 0000", lvs[k], state, dut_tick);
      end
      step(1'b1, 1'b0, lvs[k]);
      n_checks++;
      if (inv_period !== 8'(exp_p[k])) begin
        n_fail++; $display("FAIL level_period lv=%0d inv_period=%0d want %0d", lvs[k], inv_period, exp_p[k]);
      end
      // level wanders outside LOAD and must be ignored
      for (int c = 1; c <= 2 * exp_p[k]; c++) begin
        step(1'b1, 1'b0, $urandom_range(0, 7));
        n_checks++;
        if (inv_tick !== (c % exp_p[k] == 0)) begin
          n_fail++; $display("FAIL level_spacing lv=%0d c=%0d inv_tick=%b want %b", lvs[k], c, inv_tick, c % exp_p[k] == 0);
        end
      end
    end
  endtask

  task automatic test_pause();
    step(1'b1, 1'b1, 0);
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);
    for (int c = 0; c < 10; c++) begin
      step(1'b0, 1'b0, 0);
      n_checks++;
      if ({state, dut_tick} !== {2'd3, 4'd0}) begin
        n_fail++; $display("FAIL pause_hold c=%0d state=%0d ticks=%b want 3 0000", c, state, dut_tick);
      end
    end
    for (int c = 0; c < 2; c++) begin
      step(1'b1, 1'b0, 0);
      n_checks++;
      if ({state, shot_tick} !== {2'd2, c == 1}) begin
        n_fail++; $display("FAIL pause_resume c=%0d state=%0d shot=%b want 2 %b", c, state, shot_tick, c == 1);
      end
    end
  endtask

  task automatic test_lvl_pause();
    step(1'b1, 1'b1, 0);
    for (int c = 0; c <= 7; c++) step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0);
    n_checks++;
    if ({state, dut_tick} !== {2'd1, 4'd0}) begin
      n_fail++; $display("FAIL lvlpause_load state=%0d ticks=%b want 1 0000", state, dut_tick);
    end
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 0);
      n_checks++;
      if ({state, dut_tick} !== {2'd3, 4'd0}) begin
        n_fail++; $display("FAIL lvlpause_hold c=%0d state=%0d ticks=%b want 3 0000", c, state, dut_tick);
      end
    end
    for (int c = 0; c <= 3; c++) begin
      step(1'b1, 1'b0, 0);
      n_checks++;
      if ({state, dut_tick} !== {2'd2, 1'b0, 1'b0, c == 3, 1'b0}) begin
        n_fail++; $display("FAIL lvlpause_resume c=%0d state=%0d ticks=%b want 2 %b", c, state, dut_tick, {2'b0, c == 3, 1'b0});
      end
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    step(1'b1, 1'b1, 3);
    step(1'b1, 1'b0, 3);
    for (int c = 0; c < 10 && seen == 0; c++) begin
      step(1'b1, 1'b0, 3);
      if (shot_tick === 1'b1) seen = 1;
    end
    n_checks++;
    if (seen == 0 || inv_period !== 8'd8) begin
      n_fail++; $display("FAIL async_setup shot_seen=%0d inv_period=%0d want 1 8", seen, inv_period);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({state, dut_tick, inv_period} !== {2'd0, 4'd0, 8'd20}) begin
      n_fail++; $display("FAIL async_reset state=%0d ticks=%b inv_period=%0d want 0 0000 20", state, dut_tick, inv_period);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    m_reset();
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      step($urandom_range(0, 7) != 0, $urandom_range(0, 39) == 0, $urandom_range(0, 7));
      n_checks++;
      if ({state, dut_tick, inv_period} !== {2'(m_state), m_tick, 8'(m_inv)}) begin
        n_fail++;
        $display("FAIL random c=%0d state=%0d ticks=%b inv_period=%0d want %0d %b %0d", c, state, dut_tick, inv_period, m_state, m_tick, m_inv);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_align();
    test_levels();
    test_pause();
    test_lvl_pause();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
